// File: rtl/argmax_unit_pkg.sv
// Shared fixed-point types and enums for the classifier datapath.
package argmax_unit_pkg;

    // Signed score format: INTEGER_WIDTH integer bits, FRACTION_WIDTH fraction bits.
    localparam int INTEGER_WIDTH  = 8;
    localparam int FRACTION_WIDTH = 8;

    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_type;

    typedef enum logic [1:0] {
        ActNone,
        ActRelu,
        ActSigmoid
    } activation_type;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } argmax_state_type;

endpackage

// File: rtl/argmax_unit.sv
// Sequential argmax over the scores of the final dense layer.
// A rising edge on inputs_ready captures all scores, then one entry is compared
// per cycle; index/output_ready appear NUM_INPUTS edges after the capture edge.
// Optional build macro ARGMAX_CONFIDENCE_EN adds the max_value output.
module argmax_unit
    import argmax_unit_pkg::*;
#(
    parameter int unsigned  NUM_INPUTS  = 10,
    localparam int unsigned INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        inputs_ready,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] inputs [NUM_INPUTS],
    output logic [INDEX_WIDTH-1:0]                      index,
    output logic                                        output_ready
`ifdef ARGMAX_CONFIDENCE_EN
    ,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] max_value
`endif
);

    // One extra bit so the counter can reach NUM_INPUTS, the "all compared" mark.
    localparam int unsigned         CNT_WIDTH = INDEX_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_END  = CNT_WIDTH'(NUM_INPUTS);

    argmax_state_type       state_q, state_d;
    logic                   ready_q;
    logic                   start;
    logic [CNT_WIDTH-1:0]   counter_q, counter_d;
    fixed_type              best_value_q, best_value_d;
    logic [INDEX_WIDTH-1:0] best_index_q, best_index_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   output_ready_q, output_ready_d;
    fixed_type              buffer_q [NUM_INPUTS];
    fixed_type              candidate;
`ifdef ARGMAX_CONFIDENCE_EN
    fixed_type              max_value_q, max_value_d;
`endif

    assign start = inputs_ready && !ready_q;

    // Sample inputs_ready for rising-edge start detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= inputs_ready;
        end
    end

    // Snapshot of the scores; later input changes cannot disturb a scan.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                buffer_q[i] <= '0;
            end
        end else if (start) begin
            buffer_q <= inputs;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            counter_q      <= '0;
            best_value_q   <= '0;
            best_index_q   <= '0;
            index_q        <= '0;
            output_ready_q <= 1'b0;
`ifdef ARGMAX_CONFIDENCE_EN
            max_value_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            best_value_q   <= best_value_d;
            best_index_q   <= best_index_d;
            index_q        <= index_d;
            output_ready_q <= output_ready_d;
`ifdef ARGMAX_CONFIDENCE_EN
            max_value_q    <= max_value_d;
`endif
        end
    end

    // Next-state: start wins in every state; otherwise scan one entry per cycle.
    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        best_value_d   = best_value_q;
        best_index_d   = best_index_q;
        index_d        = index_q;
        output_ready_d = output_ready_q;
`ifdef ARGMAX_CONFIDENCE_EN
        max_value_d    = max_value_q;
`endif
        candidate      = buffer_q[counter_q[INDEX_WIDTH-1:0]];

        if (start) begin
            best_value_d   = inputs[0];
            best_index_d   = '0;
            counter_d      = CNT_WIDTH'(1);
            output_ready_d = 1'b0;
            state_d        = StScan;
        end else begin
            unique case (state_q)
                StScan: begin
                    if (counter_q == CNT_END) begin
                        index_d        = best_index_q;
                        output_ready_d = 1'b1;
`ifdef ARGMAX_CONFIDENCE_EN
                        max_value_d    = best_value_q;
`endif
                        state_d        = StDone;
                    end else begin
                        // Strict compare keeps the lowest index on ties.
                        if (candidate > best_value_q) begin
                            best_value_d = candidate;
                            best_index_d = counter_q[INDEX_WIDTH-1:0];
                        end
                        counter_d = counter_q + CNT_WIDTH'(1);
                    end
                end
                StIdle, StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign index        = index_q;
    assign output_ready = output_ready_q;
`ifdef ARGMAX_CONFIDENCE_EN
    assign max_value    = max_value_q;
`endif

endmodule

// File: doc/argmax_unit.md
ARGMAX_UNIT -- requirements
Module: argmax_unit

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 10, number of scores from the final dense layer; legal range 2..256.
REQ-002 SHALL have localparam INDEX_WIDTH = $clog2(NUM_INPUTS).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port inputs_ready  input  1  level from the upstream layer's outputs_ready; high means the scores are valid.
REQ-006 SHALL have port inputs  input  NUM_INPUTS x signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  layer scores.
REQ-007 SHALL have port index  output  INDEX_WIDTH  position of the maximum score.
REQ-008 SHALL have port output_ready  output  1  level; high while index is valid.
REQ-009 SHALL have port max_value  output  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  winning score; present only under ARGMAX_CONFIDENCE_EN.

Function
REQ-010 SHALL register inputs_ready each cycle and detect a start on its rising edge: inputs_ready=1 and previous sample=0.
REQ-011 SHALL use FSM states IDLE, SCAN, DONE.
REQ-012 On start in any state: copy all inputs into an internal buffer; best_value<=inputs[0]; best_index<=0; counter<=1; output_ready<=0; go to SCAN.
REQ-013 In SCAN, each cycle: if buffer[counter] > best_value (signed, strict), load best_value and best_index from that entry; counter increments.
REQ-014 Equal scores SHALL resolve to the lowest index.
REQ-015 When the entry at counter=NUM_INPUTS-1 has been compared: index<=final best_index; output_ready<=1; go to DONE.
REQ-016 output_ready SHALL first be high exactly NUM_INPUTS rising edges after the start-capture edge, with the capture edge counted as edge 0.
REQ-017 A start during SCAN SHALL abort the current scan and restart on the new data; no result is produced for the aborted scan.
REQ-018 In DONE, index and output_ready SHALL hold until the next start; a start clears output_ready on the capture edge.
REQ-019 Changes on inputs after the capture edge SHALL NOT affect the result.
REQ-020 inputs_ready held high SHALL NOT retrigger; a new start requires inputs_ready to go low first.

Reset
REQ-021 Reset SHALL force state=IDLE, index=0, output_ready=0, max_value=0, counter=0, best registers=0, and the inputs_ready sample register=0.
REQ-022 inputs_ready already high on the first edge after reset release SHALL count as a start.
REQ-023 Reset during SCAN SHALL discard the scan; no output_ready SHALL follow.

Configuration
REQ-024 Macro ARGMAX_CONFIDENCE_EN defined: the max_value port exists and SHALL update together with index at the DONE transition, then hold.
REQ-025 ARGMAX_CONFIDENCE_EN undefined: the max_value port and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-026 INTEGER_WIDTH and FRACTION_WIDTH SHALL come from the shared include/package; no local redefinition.
REQ-027 The FSM state typedef (argmax_state_type) SHALL be added to the shared package beside activation_type.
REQ-028 The design SHALL be a single module with no sub-modules; the compare/select logic is inline.

Verification
REQ-029 Scores {0.5,-1,3.25,2,0,0,0,0,0,0}, inputs_ready rising -> index=2, output_ready high on edge 10 after capture; max_value=3.25 with the macro defined.
REQ-030 Scores all -2.0 -> index=0; ties {1,4,4,...} -> index=1.
REQ-031 Max at last position, inputs[9]=7.5, others 0 -> index=9; all-negative scores with inputs[6]=-0.25 the largest -> index=6, which proves signed compare.
REQ-032 Start with max at 3; new rising edge at edge 4 with max at 8 -> exactly one output_ready, index=8, at edge 10 after the second capture.
REQ-033 Reset asserted mid-SCAN at edge 5 -> outputs at 0 immediately, no output_ready afterwards; inputs_ready held high through release -> new scan starts and completes.
REQ-034 Inputs changed after capture, and inputs_ready held high for 30 cycles -> result reflects the captured data only, with a single completion.
